// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the byte-addressed data memory.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    // Bit k enables byte offset k (offset 0 is the most significant byte).
    function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Big-endian lane steering: extracts and extends load data from a stored word,
// and replicates right-justified store data onto every lane it may land in.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        uns_i,
    input  logic [31:0] st_data_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] st_word_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed lane(s), then right-justify with sign or zero fill.
    always_comb begin
        case (off_i)
            2'd0:    byte_sel = word_i[31:24];
            2'd1:    byte_sel = word_i[23:16];
            2'd2:    byte_sel = word_i[15:8];
            default: byte_sel = word_i[7:0];
        endcase
        half_sel = off_i[1] ? word_i[15:0] : word_i[31:16];
        case (size_i)
            SZ_BYTE: ld_data_o = {{24{~uns_i & byte_sel[7]}}, byte_sel};
            SZ_HALF: ld_data_o = {{16{~uns_i & half_sel[15]}}, half_sel};
            default: ld_data_o = word_i;
        endcase
    end

    // Replication puts the store data on every candidate lane; byte enables pick the real one.
    always_comb begin
        case (size_i)
            SZ_BYTE: st_word_o = {4{st_data_i[7:0]}};
            SZ_HALF: st_word_o = {2{st_data_i[15:0]}};
            default: st_word_o = st_data_i;
        endcase
    end

endmodule

// File: rtl/byte_data_mem.sv
// Byte-addressed data memory with valid/ready requests, one-cycle registered
// responses, error reporting and an optional post-reset zero-clear sweep.
module byte_data_mem
    import dmem_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DEPTH_WORDS    = 64,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0]      mem_q [DEPTH_WORDS];
    state_t           state_q, state_d;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
    logic             ready_q;
    logic             rsp_valid_q, rsp_err_q;
    logic [31:0]      rsp_rdata_q;

    logic             accept, req_err, out_of_range, store_ok, clr_active;
    logic [1:0]       off;
    logic [IDX_W-1:0] word_idx, wr_idx;
    logic [3:0]       lane_be, wr_en;
    logic [31:0]      rd_word, ld_data, st_word, wr_word;

    assign accept       = req_valid & ready_q;
    assign off          = req_addr[1:0];
    assign word_idx     = req_addr[IDX_W+1:2];
    // Any address bit above the array's byte range makes the request illegal rather than aliasing.
    assign out_of_range = |req_addr[ADDR_W-1:IDX_W+2];
    assign req_err      = (req_size == SZ_RSVD) | misaligned(req_size, off) | out_of_range;
    assign store_ok     = accept & req_write & ~req_err;
    assign clr_active   = (state_q == ST_CLEAR);
    assign lane_be      = lane_enables(req_size, off);
    assign rd_word      = mem_q[word_idx];
    assign wr_idx       = clr_active ? clr_idx_q : word_idx;
    assign wr_word      = clr_active ? 32'h0 : st_word;

    dmem_lane_align u_align (
        .word_i    (rd_word),
        .size_i    (req_size),
        .off_i     (off),
        .uns_i     (req_unsigned),
        .st_data_i (req_wdata),
        .ld_data_o (ld_data),
        .st_word_o (st_word)
    );

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane_we
        assign wr_en[gi] = clr_active | (store_ok & lane_be[gi]);
    end

    // Next-state logic: sweep every word once, then serve requests.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == ST_CLEAR) begin
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == IDX_W'(DEPTH_WORDS - 1)) begin
                state_d = ST_IDLE;
            end
        end
    end

    // State, clear counter and registered ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            ready_q   <= (state_d == ST_IDLE);
        end
    end

    // Byte-lane writes from either the clear sweep or an accepted legal store.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_en[k]) begin
                    mem_q[wr_idx][31-8*k -: 8] <= wr_word[31-8*k -: 8];
                end
            end
        end
    end

    // One response per accept, issued the following cycle; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= accept;
            rsp_err_q   <= accept & req_err;
            rsp_rdata_q <= (accept & ~req_write & ~req_err) ? ld_data : 32'h0;
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_byte_data_mem.sv
// Bench for byte_data_mem: byte-array reference model, per-cycle output compare,
// directed requests with hand-computed expectations.
module tb_byte_data_mem;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    always #5 clk = ~clk;

    byte_data_mem #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .CLEAR_ON_RESET(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       cur;
    logic [7:0] mm [4*DEPTH];
    int         checks = 0;
    int         passes = 0;
    int         ncount = 0;
    int         since = 0;
    bit         armed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Cycles since reset was last sampled; ready must appear after DEPTH clear cycles.
    always @(posedge clk) begin
        if (rst) begin
            since <= 0;
            armed <= 1'b1;
        end else if (since < 100000) begin
            since <= since + 1;
        end
    end

    // Per-cycle compare of outputs against the model's expected response stream.
    always @(negedge clk) begin
        ncount <= ncount + 1;
        if (armed) begin
            chk("req_ready", {31'b0, req_ready}, {31'b0, since >= DEPTH});
            if (exp_q.size() > 0 && exp_q[0].due == ncount + 1) begin
                cur = exp_q.pop_front();
                chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
                if (rsp_valid === 1'b1) begin
                    chk("rsp_err", {31'b0, rsp_err}, {31'b0, cur.err});
                    chk("rsp_rdata", rsp_rdata, cur.rdata);
                end
            end else begin
                chk("rsp_valid idle", {31'b0, rsp_valid}, 32'd0);
            end
        end
    end

    // Reference model over a byte array: legality rules, big-endian stores, extended loads.
    task automatic model(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                         input logic [31:0] d, output logic err, output logic [31:0] r);
        int i;
        err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
              || (a >= 32'(4*DEPTH));
        r = 32'h0;
        i = int'(a[7:0]);
        if (!err) begin
            if (w) begin
                case (sz)
                    2'b00: mm[i] = d[7:0];
                    2'b01: begin mm[i] = d[15:8]; mm[i+1] = d[7:0]; end
                    default: begin
                        mm[i] = d[31:24]; mm[i+1] = d[23:16]; mm[i+2] = d[15:8]; mm[i+3] = d[7:0];
                    end
                endcase
            end else begin
                case (sz)
                    2'b00: r = u ? {24'h0, mm[i]} : {{24{mm[i][7]}}, mm[i]};
                    2'b01: r = u ? {16'h0, mm[i], mm[i+1]} : {{16{mm[i][7]}}, mm[i], mm[i+1]};
                    default: r = {mm[i], mm[i+1], mm[i+2], mm[i+3]};
                endcase
            end
        end
    endtask

    // Present one request for one cycle; if it will be accepted, queue the model's response.
    task automatic req(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                       input logic [31:0] d, input bit lit, input logic lerr,
                       input logic [31:0] lrd, input string name);
        logic        merr;
        logic [31:0] mrd;
        exp_t        e;
        @(negedge clk);
        #1;
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = d;
        if (req_ready === 1'b1 && !rst) begin
            model(w, sz, u, a, d, merr, mrd);
            e.due = ncount + 1; e.err = merr; e.rdata = mrd;
            exp_q.push_back(e);
            if (lit) begin
                chk({name, " err"}, {31'b0, merr}, {31'b0, lerr});
                chk({name, " rdata"}, mrd, lrd);
            end
        end else if (lit) begin
            chk({name, " accepted"}, {31'b0, req_ready}, 32'd1);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
            req_valid = 1'b0;
        end
    endtask

    // Pulse reset, then count how many cycles ready stays low after release.
    task automatic do_reset(input string name);
        int n;
        int guard;
        @(negedge clk);
        #1;
        rst = 1'b1; req_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4*DEPTH; i++) mm[i] = 8'h00;
        n = (req_ready === 1'b1) ? 0 : 1;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            if (req_ready !== 1'b1) n++;
            guard++;
        end
        chk(name, 32'(n), 32'(DEPTH));
    endtask

    initial begin
        do_reset("clear cycles after reset");

        // Cleared contents read as zero.
        req(0, 2'b10, 0, 32'h40, 0, 1, 0, 32'h0, "ld word 0x40 cleared");
        req(0, 2'b00, 1, 32'hFF, 0, 1, 0, 32'h0, "ld byte 0xFF cleared");

        // Word store then narrow loads (big-endian lanes).
        req(1, 2'b10, 0, 32'h10, 32'h11223344, 1, 0, 32'h0, "st word 0x10");
        req(0, 2'b00, 1, 32'h10, 0, 1, 0, 32'h00000011, "ld byte 0x10");
        req(0, 2'b00, 1, 32'h13, 0, 1, 0, 32'h00000044, "ld byte 0x13");
        req(0, 2'b01, 1, 32'h12, 0, 1, 0, 32'h00003344, "ld half 0x12");
        req(0, 2'b01, 0, 32'h10, 0, 1, 0, 32'h00001122, "ld half 0x10 s");
        req(0, 2'b10, 0, 32'h10, 0, 1, 0, 32'h11223344, "ld word 0x10");

        // Byte store into one lane, signed and unsigned readback.
        req(1, 2'b10, 0, 32'h20, 32'h55667788, 1, 0, 32'h0, "st word 0x20");
        req(1, 2'b00, 0, 32'h21, 32'hABCDEF80, 1, 0, 32'h0, "st byte 0x21");
        req(0, 2'b00, 0, 32'h21, 0, 1, 0, 32'hFFFFFF80, "ld byte 0x21 s");
        req(0, 2'b00, 1, 32'h21, 0, 1, 0, 32'h00000080, "ld byte 0x21 u");
        req(0, 2'b10, 0, 32'h20, 0, 1, 0, 32'h55807788, "ld word 0x20 lanes");

        // Half store to upper offset and sign extension.
        req(1, 2'b01, 0, 32'h16, 32'h00008001, 1, 0, 32'h0, "st half 0x16");
        req(0, 2'b01, 0, 32'h16, 0, 1, 0, 32'hFFFF8001, "ld half 0x16 s");
        req(0, 2'b01, 1, 32'h16, 0, 1, 0, 32'h00008001, "ld half 0x16 u");
        req(0, 2'b10, 0, 32'h14, 0, 1, 0, 32'h00008001, "ld word 0x14");
        idle(2);

        // Illegal requests: no write, error flagged, data zero.
        req(1, 2'b01, 0, 32'h01, 32'hFFFFFFFF, 1, 1, 32'h0, "st half misaligned");
        req(1, 2'b10, 0, 32'h02, 32'hFFFFFFFF, 1, 1, 32'h0, "st word misaligned");
        req(0, 2'b11, 0, 32'h10, 0, 1, 1, 32'h0, "ld reserved size");
        req(1, 2'b10, 0, 32'h100, 32'hFFFFFFFF, 1, 1, 32'h0, "st word out of range");
        req(0, 2'b10, 0, 32'h100, 0, 1, 1, 32'h0, "ld word out of range");
        req(0, 2'b00, 1, 32'hFFFFFFFC, 0, 1, 1, 32'h0, "ld byte high addr");
        req(0, 2'b10, 0, 32'h00, 0, 1, 0, 32'h0, "ld word 0x0 untouched");
        req(0, 2'b10, 0, 32'h10, 0, 1, 0, 32'h11223344, "ld word 0x10 untouched");
        idle(1);

        // Back-to-back store then load of the same word.
        req(1, 2'b10, 0, 32'h08, 32'hCAFEF00D, 1, 0, 32'h0, "b2b st 0x8");
        req(0, 2'b10, 0, 32'h08, 0, 1, 0, 32'hCAFEF00D, "b2b ld 0x8");
        idle(2);

        // Reset with a response in flight.
        req(1, 2'b10, 0, 32'h30, 32'h12345678, 1, 0, 32'h0, "st word 0x30 pre-reset");
        do_reset("clear cycles after reset with pending rsp");
        req(0, 2'b10, 0, 32'h10, 0, 1, 0, 32'h0, "ld word 0x10 after reset");

        // Reset again mid-clear, with stray requests that must be ignored.
        @(negedge clk);
        #1;
        rst = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) req(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0, "");
        do_reset("clear cycles after mid-clear reset");
        req(0, 2'b10, 0, 32'h10, 0, 1, 0, 32'h0, "ld word 0x10 after re-clear");
        req(0, 2'b10, 0, 32'h30, 0, 1, 0, 32'h0, "ld word 0x30 after re-clear");
        idle(4);

        chk("response queue drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
